// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Brief    : Shared Y86-64 constants (icodes, status codes), the SEQ stage
//            controller state enum and the memory-stage classifier.
//            Optional macro SEQ_SINGLE_STEP_EN adds the S_STEPWAIT state.
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Processor status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
    S_HALTED    = 4'd7,
    S_ERROR     = 4'd8
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_STEPWAIT  = 4'd9
`endif
  } seq_state_t;

  // Instructions that touch data memory (loads, stores, stack ops)
  function automatic logic needs_mem(input logic [3:0] icode);
    logic r;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
      default:                                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : W-bit up counter with synchronous clear that sticks at all-ones
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear dominates, increment only below the ceiling
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_stage_controller.sv
`default_nettype none
// ============================================================================
// Module   : seq_stage_controller
// Brief    : Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps one
//            stage per cycle, handles the data-memory handshake with a
//            timeout, reports processor status and keeps saturating
//            busy-cycle / retired-instruction counters.
//            Optional macro SEQ_SINGLE_STEP_EN adds the step input and a
//            STEPWAIT pause after every PC update.
// Revision : 1.0 - initial release
// ============================================================================
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             halt,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_req,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  // Timeout counter only needs to reach MEM_TIMEOUT-1
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_op_q, mem_op_d;
  logic             fetch_en_q, fetch_en_d;
  logic             decode_en_q, decode_en_d;
  logic             execute_en_q, execute_en_d;
  logic             mem_req_q, mem_req_d;
  logic             wb_en_q, wb_en_d;
  logic             pc_en_q, pc_en_d;
  logic             busy_q, busy_d;
  logic             retire_halt;
  logic             cyc_inc;
  logic             ret_inc;

  // Next-state, status and timeout logic; outputs are decoded from the next
  // state so the registered enables line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    tmo_d       = tmo_q;
    mem_op_d    = mem_op_q;
    retire_halt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // icode is only guaranteed in DECODE, so classify it here
        mem_op_d = needs_mem(icode);
        if (imem_error) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_ERROR;
          stat_d  = STAT_INS;
        end else if (halt) begin
          state_d     = S_HALTED;
          stat_d      = STAT_HLT;
          retire_halt = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (mem_op_q) begin
          state_d = S_MEMORY;
          tmo_d   = '0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (mem_ack) begin
          // an address fault reported with the ack takes precedence
          if (dmem_error) begin
            state_d = S_ERROR;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
`ifdef SEQ_SINGLE_STEP_EN
        state_d = S_STEPWAIT;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_STEPWAIT: begin
        if (step) state_d = S_FETCH;
      end
`endif
      S_HALTED, S_ERROR: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    fetch_en_d   = (state_d == S_FETCH);
    decode_en_d  = (state_d == S_DECODE);
    execute_en_d = (state_d == S_EXECUTE);
    mem_req_d    = (state_d == S_MEMORY);
    wb_en_d      = (state_d == S_WRITEBACK);
    pc_en_d      = (state_d == S_PCUPD);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_HALTED) ||
                     (state_d == S_ERROR));
  end

  // FSM state, status and registered Moore outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      stat_q       <= STAT_AOK;
      tmo_q        <= '0;
      mem_op_q     <= 1'b0;
      fetch_en_q   <= 1'b0;
      decode_en_q  <= 1'b0;
      execute_en_q <= 1'b0;
      mem_req_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      pc_en_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stat_q       <= stat_d;
      tmo_q        <= tmo_d;
      mem_op_q     <= mem_op_d;
      fetch_en_q   <= fetch_en_d;
      decode_en_q  <= decode_en_d;
      execute_en_q <= execute_en_d;
      mem_req_q    <= mem_req_d;
      wb_en_q      <= wb_en_d;
      pc_en_q      <= pc_en_d;
      busy_q       <= busy_d;
    end
  end

  // A paused single-step wait is busy but does not consume execution cycles
`ifdef SEQ_SINGLE_STEP_EN
  assign cyc_inc = busy_q && (state_q != S_STEPWAIT);
`else
  assign cyc_inc = busy_q;
`endif
  assign ret_inc = pc_en_q || retire_halt;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (ret_inc),
    .count (retired_count)
  );

  assign fetch_en   = fetch_en_q;
  assign decode_en  = decode_en_q;
  assign execute_en = execute_en_q;
  assign mem_req    = mem_req_q;
  assign wb_en      = wb_en_q;
  assign pc_en      = pc_en_q;
  assign busy       = busy_q;
  assign stat       = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_stage_controller
// Brief    : Self-checking bench for seq_stage_controller. Programs of
//            instructions are expanded into per-cycle expected outputs from
//            the stage-sequencing rules, then replayed against the DUT.
//            Honours SEQ_SINGLE_STEP_EN (step tied high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_stage_controller;

  localparam int MT = 16;
  localparam int CW = 4;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  logic          clock = 1'b0;
  logic          reset, start, halt, instr_valid, imem_error, mem_ack, dmem_error;
  logic [3:0]    icode;
  logic          fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, busy;
  logic [2:0]    stat;
  logic [CW-1:0] cycle_count, retired_count;

  always #5 clock = ~clock;

  seq_stage_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .icode         (icode),
    .halt          (halt),
    .instr_valid   (instr_valid),
    .imem_error    (imem_error),
    .mem_ack       (mem_ack),
    .dmem_error    (dmem_error),
`ifdef SEQ_SINGLE_STEP_EN
    .step          (1'b1),
`endif
    .fetch_en      (fetch_en),
    .decode_en     (decode_en),
    .execute_en    (execute_en),
    .mem_req       (mem_req),
    .wb_en         (wb_en),
    .pc_en         (pc_en),
    .stat          (stat),
    .busy          (busy),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  typedef struct packed {
    logic       start;
    logic [3:0] icode;
    logic       halt;
    logic       valid;
    logic       imerr;
    logic       ack;
    logic       derr;
  } stim_t;

  // en = {fetch, decode, execute, mem_req, wb, pc}
  typedef struct packed {
    logic [5:0] en;
    logic       busy;
    logic [2:0] stat;
    logic       cnt;
    logic       ret;
  } want_t;

  // ack_dly = 0 means memory never answers
  typedef struct packed {
    logic [3:0] icode;
    logic       halt;
    logic       valid;
    logic       imerr;
    logic [4:0] ack_dly;
    logic       derr;
  } ins_t;

  stim_t sq[$];
  want_t wq[$];
  ins_t  prog[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic bit mem_op(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic ins_t mk(input logic [3:0] ic, input logic h, input logic v,
                              input logic ie, input logic [4:0] ad, input logic de);
    ins_t r;
    r.icode = ic; r.halt = h; r.valid = v; r.imerr = ie; r.ack_dly = ad; r.derr = de;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > (2 ** CW) - 1) ? (2 ** CW) - 1 : v;
  endfunction

  task automatic push(input stim_t s, input logic [5:0] en, input logic b,
                      input logic [2:0] st, input logic c, input logic r);
    want_t w;
    w.en = en; w.busy = b; w.stat = st; w.cnt = c; w.ret = r;
    sq.push_back(s);
    wq.push_back(w);
  endtask

  // Terminal state: nothing moves, start must be ignored
  task automatic terminal(input stim_t s0, input logic [2:0] st);
    stim_t s;
    s = s0;
    for (int k = 0; k < 3; k++) begin
      s.start = 1'b1;
      s.ack   = 1'($urandom % 2);
      s.derr  = 1'($urandom % 2);
      push(s, 6'b000000, 1'b0, st, 1'b0, 1'b0);
    end
  endtask

  // Expand one instruction into its cycle-by-cycle expectation
  task automatic gen_instr(input ins_t in, output bit term);
    stim_t s;
    s.start = 1'($urandom % 2);
    s.icode = in.icode; s.halt = in.halt; s.valid = in.valid; s.imerr = in.imerr;
    s.ack = 1'b0; s.derr = 1'b0;
    term = 1'b0;
    push(s, 6'b100000, 1'b1, AOK, 1'b1, 1'b0);
    push(s, 6'b010000, 1'b1, AOK, 1'b1, in.halt && in.valid && !in.imerr);
    if (in.imerr)       begin terminal(s, ADR); term = 1'b1; return; end
    if (!in.valid)      begin terminal(s, INS); term = 1'b1; return; end
    if (in.halt)        begin terminal(s, HLT); term = 1'b1; return; end
    push(s, 6'b001000, 1'b1, AOK, 1'b1, 1'b0);
    if (mem_op(in.icode)) begin
      if (in.ack_dly == 0) begin
        for (int k = 0; k < MT; k++) begin
          s.derr = 1'($urandom % 2);
          push(s, 6'b000100, 1'b1, AOK, 1'b1, 1'b0);
        end
        terminal(s, ADR); term = 1'b1; return;
      end
      for (int k = 1; k <= int'(in.ack_dly); k++) begin
        s.ack  = (k == int'(in.ack_dly));
        s.derr = s.ack ? in.derr : 1'($urandom % 2);
        push(s, 6'b000100, 1'b1, AOK, 1'b1, 1'b0);
      end
      s.ack = 1'b0; s.derr = 1'b0;
      if (in.derr) begin terminal(s, ADR); term = 1'b1; return; end
    end
    push(s, 6'b000010, 1'b1, AOK, 1'b1, 1'b0);
    push(s, 6'b000001, 1'b1, AOK, 1'b1, 1'b1);
`ifdef SEQ_SINGLE_STEP_EN
    push(s, 6'b000000, 1'b1, AOK, 1'b0, 1'b0);
`endif
  endtask

  // Build expectations for prog[], optionally dropping trailing cycles so the
  // next reset lands mid-instruction
  task automatic build_run(input int cut);
    stim_t s;
    bit    term;
    sq.delete(); wq.delete();
    s = '0;
    push(s, 6'b000000, 1'b0, AOK, 1'b0, 1'b0);
    s.start = 1'b1;
    push(s, 6'b000000, 1'b0, AOK, 1'b0, 1'b0);
    foreach (prog[i]) begin
      gen_instr(prog[i], term);
      if (term) break;
    end
    for (int k = 0; k < cut; k++) begin
      if (wq.size() > 3) begin
        void'(wq.pop_back());
        void'(sq.pop_back());
      end
    end
  endtask

  task automatic exec_run(input string name);
    int cyc, ret;
    reset = 1'b1; start = 1'b0; icode = 4'h0; halt = 1'b0; instr_valid = 1'b1;
    imem_error = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
    @(negedge clock);
    check_eq({name, ".rst_en"}, {26'd0, fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en}, 32'd0);
    check_eq({name, ".rst_busy"}, {31'd0, busy}, 32'd0);
    check_eq({name, ".rst_stat"}, {29'd0, stat}, {29'd0, AOK});
    check_eq({name, ".rst_cyc"}, 32'(cycle_count), 32'd0);
    check_eq({name, ".rst_ret"}, 32'(retired_count), 32'd0);
    reset = 1'b0;
    cyc = 0; ret = 0;
    foreach (wq[i]) begin
      check_eq({name, ".en"}, {26'd0, fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en},
               {26'd0, wq[i].en});
      check_eq({name, ".busy"}, {31'd0, busy}, {31'd0, wq[i].busy});
      check_eq({name, ".stat"}, {29'd0, stat}, {29'd0, wq[i].stat});
      cyc += int'(wq[i].cnt);
      ret += int'(wq[i].ret);
      start       = sq[i].start;
      icode       = sq[i].icode;
      halt        = sq[i].halt;
      instr_valid = sq[i].valid;
      imem_error  = sq[i].imerr;
      mem_ack     = sq[i].ack;
      dmem_error  = sq[i].derr;
      @(negedge clock);
    end
    check_eq({name, ".cycle_count"}, 32'(cycle_count), 32'(sat(cyc)));
    check_eq({name, ".retired_count"}, 32'(retired_count), 32'(sat(ret)));
  endtask

  task automatic do_run(input string name, input int cut);
    build_run(cut);
    exec_run(name);
  endtask

  function automatic ins_t rand_ins();
    ins_t r;
    r.icode   = 4'($urandom_range(0, 11));
    r.halt    = ($urandom % 8) == 0;
    r.valid   = ($urandom % 16) != 0;
    r.imerr   = ($urandom % 16) == 0;
    r.derr    = ($urandom % 8) == 0;
    case ($urandom % 10)
      0:       r.ack_dly = 5'd0;
      1:       r.ack_dly = 5'($urandom_range(1, MT));
      default: r.ack_dly = 5'($urandom_range(1, 5));
    endcase
    return r;
  endfunction

  initial begin
    // irmovq then halt
    prog.delete();
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h0, 1, 1, 0, 5'd0, 0));
    do_run("irmov_halt", 0);

    // rmmovq, ack on third memory cycle, then halt
    prog.delete();
    prog.push_back(mk(4'h4, 0, 1, 0, 5'd3, 0));
    prog.push_back(mk(4'h0, 1, 1, 0, 5'd0, 0));
    do_run("rmmov_ack3", 0);

    // memory never answers
    prog.delete();
    prog.push_back(mk(4'h4, 0, 1, 0, 5'd0, 0));
    do_run("mem_timeout", 0);

    // ack on the very last allowed cycle still completes
    prog.delete();
    prog.push_back(mk(4'h9, 0, 1, 0, 5'd16, 0));
    prog.push_back(mk(4'h0, 1, 1, 0, 5'd0, 0));
    do_run("ack_last", 0);

    // ack and address fault together
    prog.delete();
    prog.push_back(mk(4'h5, 0, 1, 0, 5'd2, 1));
    do_run("ack_err", 0);

    // imem_error with invalid instruction -> ADR
    prog.delete();
    prog.push_back(mk(4'h6, 0, 0, 1, 5'd0, 0));
    do_run("adr_beats_ins", 0);

    // invalid instruction alone -> INS
    prog.delete();
    prog.push_back(mk(4'h6, 0, 0, 0, 5'd0, 0));
    do_run("ins", 0);

    // reset while memory request is outstanding
    prog.delete();
    prog.push_back(mk(4'h4, 0, 1, 0, 5'd0, 0));
    do_run("mid_mem", 13);
    do_run("after_mid_mem", 0);

    // long run to saturate 4-bit counters
    prog.delete();
    for (int k = 0; k < 5; k++) prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h6, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h1, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h2, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h3, 0, 1, 0, 5'd0, 0));
    prog.push_back(mk(4'h0, 1, 1, 0, 5'd0, 0));
    do_run("saturate", 0);

    // randomized programs, some cut short by reset
    for (int r = 0; r < 60; r++) begin
      prog.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) prog.push_back(rand_ins());
      do_run("rand", ($urandom % 3 == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
